// File: rtl/rpn_executor.sv
// rpn_executor: command execution stage for the RPN calculator.
// Converts keypad/operation commands into operand-stack strobe sequences.
module rpn_executor (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [3:0]  cmd_digit,
   input  logic [31:0] stk_top,
   input  logic [31:0] stk_next,
   input  logic [5:0]  stk_count,
   input  logic        stk_error,
   output logic        stk_push,
   output logic        stk_pop,
   output logic        stk_write,
   output logic [31:0] stk_value,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {
      IDLE,
      DIVIDE,
      POP,
      PUSH,
      WRITE
   } state_t;

   localparam logic [2:0] OP_DIGIT = 3'd0;
   localparam logic [2:0] OP_ENTER = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_MUL   = 3'd4;
   localparam logic [2:0] OP_DIV   = 3'd5;
   localparam logic [2:0] OP_NEG   = 3'd6;
   localparam logic [2:0] OP_DROP  = 3'd7;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_UNDER = 2'd1;
   localparam logic [1:0] ERR_OVER  = 2'd2;
   localparam logic [1:0] ERR_DIV0  = 2'd3;

   state_t      state;
   logic        then_write;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic [31:0] div_d;
   logic [4:0]  div_cnt;

   logic [32:0] rem_sh;
   logic [32:0] rem_sub;
   logic        fits;
   logic [31:0] r_nxt;
   logic [31:0] q_nxt;
   logic        two_ok;

   assign cmd_ready = (state == IDLE);
   assign two_ok    = (stk_count >= 6'd2);

   // One restoring-division step: shift in the next dividend bit, try to subtract.
   always_comb begin
      rem_sh  = {div_r, div_q[31]};
      rem_sub = rem_sh - {1'b0, div_d};
      fits    = ~rem_sub[32];
      r_nxt   = fits ? rem_sub[31:0] : rem_sh[31:0];
      q_nxt   = {div_q[30:0], fits};
   end

   // Command sequencer with registered strobes, result and error code.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         then_write <= 1'b0;
         stk_push   <= 1'b0;
         stk_pop    <= 1'b0;
         stk_write  <= 1'b0;
         stk_value  <= '0;
         err_code   <= ERR_NONE;
         div_q      <= '0;
         div_r      <= '0;
         div_d      <= '0;
         div_cnt    <= '0;
      end else begin
         stk_push  <= 1'b0;
         stk_pop   <= 1'b0;
         stk_write <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  err_code <= ERR_NONE;
                  if (stk_error) begin
                     err_code <= ERR_OVER;
                  end else begin
                     unique case (cmd_op)
                        OP_DIGIT: begin
                           stk_value <= (stk_top * 32'd10) + {28'd0, cmd_digit};
                           stk_write <= 1'b1;
                           state     <= WRITE;
                        end
                        OP_NEG: begin
                           stk_value <= 32'd0 - stk_top;
                           stk_write <= 1'b1;
                           state     <= WRITE;
                        end
                        OP_ENTER: begin
                           if (stk_count == 6'd63) begin
                              err_code <= ERR_OVER;
                           end else begin
                              stk_push <= 1'b1;
                              state    <= PUSH;
                           end
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                           if (!two_ok) begin
                              err_code <= ERR_UNDER;
                           end else begin
                              if (cmd_op == OP_ADD)
                                 stk_value <= stk_next + stk_top;
                              else if (cmd_op == OP_SUB)
                                 stk_value <= stk_next - stk_top;
                              else
                                 stk_value <= stk_next * stk_top;
                              then_write <= 1'b1;
                              stk_pop    <= 1'b1;
                              state      <= POP;
                           end
                        end
                        OP_DIV: begin
                           if (!two_ok) begin
                              err_code <= ERR_UNDER;
                           end else if (stk_top == 32'd0) begin
                              err_code <= ERR_DIV0;
                           end else begin
                              div_q      <= stk_next;
                              div_d      <= stk_top;
                              div_r      <= '0;
                              div_cnt    <= '0;
                              then_write <= 1'b1;
                              state      <= DIVIDE;
                           end
                        end
                        OP_DROP: begin
                           if (stk_count > 6'd1) begin
                              then_write <= 1'b0;
                              stk_pop    <= 1'b1;
                              state      <= POP;
                           end else begin
                              stk_value <= '0;
                              stk_write <= 1'b1;
                              state     <= WRITE;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            DIVIDE: begin
               div_q   <= q_nxt;
               div_r   <= r_nxt;
               div_cnt <= div_cnt + 5'd1;
               if (div_cnt == 5'd31) begin
                  stk_value <= q_nxt;
                  stk_pop   <= 1'b1;
                  state     <= POP;
               end
            end
            POP: begin
               if (then_write) begin
                  stk_write <= 1'b1;
                  state     <= WRITE;
               end else begin
                  state <= IDLE;
               end
            end
            PUSH:    state <= IDLE;
            WRITE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_executor.sv
// Testbench for rpn_executor: table-driven command vectors
// plus hand-written reset and divide-abort sequences.
module tb_rpn_executor;

   logic        clock;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_digit;
   logic [31:0] stk_top;
   logic [31:0] stk_next;
   logic [5:0]  stk_count;
   logic        stk_error;
   logic        stk_push;
   logic        stk_pop;
   logic        stk_write;
   logic [31:0] stk_value;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;

   rpn_executor dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_digit (cmd_digit),
      .stk_top   (stk_top),
      .stk_next  (stk_next),
      .stk_count (stk_count),
      .stk_error (stk_error),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_write (stk_write),
      .stk_value (stk_value),
      .err_code  (err_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [3:0]  dig;
      logic [31:0] top;
      logic [31:0] nxt;
      logic [5:0]  cnt;
      logic        serr;
      int          busy;
      int          push_at;
      int          pop_at;
      int          wr_at;
      logic [31:0] val;
      logic [1:0]  err;
   } vec_t;

   localparam int NV = 17;
   vec_t v [NV];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t t);
      int busy, push_at, pop_at, wr_at, multi, nstr;
      logic [31:0] wval;
      busy = 0; push_at = 0; pop_at = 0; wr_at = 0;
      multi = 0; nstr = 0; wval = 32'hDEADBEEF;
      @(negedge clock);
      cmd_op    = t.op;
      cmd_digit = t.dig;
      stk_top   = t.top;
      stk_next  = t.nxt;
      stk_count = t.cnt;
      stk_error = t.serr;
      cmd_valid = 1'b1;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      while (!cmd_ready && busy < 100) begin
         busy++;
         if (int'(stk_push) + int'(stk_pop) + int'(stk_write) > 1) multi++;
         if (stk_push)  begin nstr++; if (push_at == 0) push_at = busy; end
         if (stk_pop)   begin nstr++; if (pop_at == 0) pop_at = busy; end
         if (stk_write) begin
            nstr++;
            if (wr_at == 0) begin wr_at = busy; wval = stk_value; end
         end
         @(posedge clock);
         #1;
      end
      if (stk_push || stk_pop || stk_write) nstr++;
      chk({t.name, " busy"}, busy, t.busy);
      chk({t.name, " push_at"}, push_at, t.push_at);
      chk({t.name, " pop_at"}, pop_at, t.pop_at);
      chk({t.name, " write_at"}, wr_at, t.wr_at);
      chk({t.name, " strobes"}, nstr,
          int'(t.push_at != 0) + int'(t.pop_at != 0) + int'(t.wr_at != 0));
      chk({t.name, " one_hot"}, multi, 0);
      chk({t.name, " err"}, {30'd0, err_code}, {30'd0, t.err});
      if (t.wr_at != 0) chk({t.name, " value"}, wval, t.val);
   endtask

   initial begin
      int cyc, seen;
      cmd_valid = 0; cmd_op = 0; cmd_digit = 0;
      stk_top = 0; stk_next = 0; stk_count = 6'd1; stk_error = 0;
      reset_n = 0;

      //           name      op dig top           next          cnt  se busy pu po wr val           err
      v[0]  = '{"dig1",     0, 1, 32'd0,        32'd0,        1,   0, 1,  0, 0, 1, 32'd1,        0};
      v[1]  = '{"dig2",     0, 2, 32'd1,        32'd0,        1,   0, 1,  0, 0, 1, 32'd12,       0};
      v[2]  = '{"add",      2, 0, 32'd5,        32'd7,        2,   0, 2,  0, 1, 2, 32'd12,       0};
      v[3]  = '{"sub",      3, 0, 32'd5,        32'd3,        2,   0, 2,  0, 1, 2, 32'hFFFFFFFE, 0};
      v[4]  = '{"mul",      4, 0, 32'h00010001, 32'h00010000, 3,   0, 2,  0, 1, 2, 32'h00010000, 0};
      v[5]  = '{"neg",      6, 0, 32'd5,        32'd0,        1,   0, 1,  0, 0, 1, 32'hFFFFFFFB, 0};
      v[6]  = '{"div",      5, 0, 32'd7,        32'd100,      2,   0, 34, 0, 33,34,32'd14,       0};
      v[7]  = '{"div0",     5, 0, 32'd0,        32'd100,      2,   0, 0,  0, 0, 0, 32'd0,        3};
      v[8]  = '{"div_und",  5, 0, 32'd0,        32'd0,        1,   0, 0,  0, 0, 0, 32'd0,        1};
      v[9]  = '{"add_und",  2, 0, 32'd5,        32'd0,        1,   0, 0,  0, 0, 0, 32'd0,        1};
      v[10] = '{"ent_full", 1, 0, 32'd5,        32'd4,        63,  0, 0,  0, 0, 0, 32'd0,        2};
      v[11] = '{"enter",    1, 0, 32'd5,        32'd4,        5,   0, 1,  1, 0, 0, 32'd0,        0};
      v[12] = '{"drop1",    7, 0, 32'd9,        32'd0,        1,   0, 1,  0, 0, 1, 32'd0,        0};
      v[13] = '{"drop3",    7, 0, 32'd9,        32'd8,        3,   0, 1,  0, 1, 0, 32'd0,        0};
      v[14] = '{"stk_err",  2, 0, 32'd5,        32'd7,        4,   1, 0,  0, 0, 0, 32'd0,        2};
      v[15] = '{"dig_wrap", 0, 15,32'hFFFFFFFF, 32'd0,        1,   0, 1,  0, 0, 1, 32'd5,        0};
      v[16] = '{"div_max",  5, 0, 32'd1,        32'hFFFFFFFF, 2,   0, 34, 0, 33,34,32'hFFFFFFFF, 0};

      #12;
      chk("rst ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst strobes", {29'd0, stk_push, stk_pop, stk_write}, 32'd0);
      chk("rst value", stk_value, 32'd0);
      chk("rst err", {30'd0, err_code}, 32'd0);
      @(negedge clock);
      reset_n = 1;

      for (int i = 0; i < NV; i++) run(v[i]);

      // abort a divide with reset in its 10th DIVIDE cycle
      @(negedge clock);
      cmd_op = 3'd5; stk_top = 32'd7; stk_next = 32'd100;
      stk_count = 6'd2; stk_error = 0; cmd_valid = 1;
      @(posedge clock);
      #1;
      cmd_valid = 0;
      chk("abort busy", {31'd0, cmd_ready}, 32'd0);
      repeat (9) @(posedge clock);
      #2;
      reset_n = 0;
      #1;
      chk("abort ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort strobes", {29'd0, stk_push, stk_pop, stk_write}, 32'd0);
      chk("abort err", {30'd0, err_code}, 32'd0);
      @(negedge clock);
      reset_n = 1;
      seen = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(posedge clock);
         #1;
         if (stk_push || stk_pop || stk_write || !cmd_ready) seen++;
      end
      chk("abort quiet", seen, 0);
      run(v[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
